// File: rtl/eaf_request_queue_if.sv
// Handshake bundle between the cache, the EAF request queue and the EAF bloom filter.
// slave = the queue itself; master = the cache/EAF side driving it.
interface eaf_request_queue_if #(
  parameter int addr_length = 32
);
  logic                   evict_valid_i;
  logic [addr_length-1:0] evict_addr_i;
  logic                   evict_ready_o;
  logic                   miss_valid_i;
  logic [addr_length-1:0] miss_addr_i;
  logic                   miss_ready_o;
  logic                   prio_valid_o;
  logic                   prio_o;
  logic                   hit_o;
  logic                   prio_ready_i;
  logic [addr_length-1:0] eaf_addr_o;
  logic                   eaf_insert_o;
  logic                   eaf_test_o;
  logic                   eaf_priority_i;
  logic                   eaf_exists_i;
  logic                   eaf_resp_i;
  logic                   timeout_o;

  modport slave (
    input  evict_valid_i, evict_addr_i, miss_valid_i, miss_addr_i, prio_ready_i,
           eaf_priority_i, eaf_exists_i, eaf_resp_i,
    output evict_ready_o, miss_ready_o, prio_valid_o, prio_o, hit_o,
           eaf_addr_o, eaf_insert_o, eaf_test_o, timeout_o
  );

  modport master (
    output evict_valid_i, evict_addr_i, miss_valid_i, miss_addr_i, prio_ready_i,
           eaf_priority_i, eaf_exists_i, eaf_resp_i,
    input  evict_ready_o, miss_ready_o, prio_valid_o, prio_o, hit_o,
           eaf_addr_o, eaf_insert_o, eaf_test_o, timeout_o
  );
endinterface

// File: rtl/eaf_request_queue.sv
// EAF front-end: evict/miss FIFOs serialised onto the EAF insert/test handshake.
// Optional EAF_REQ_FWD_EN: a miss matching a queued eviction is answered locally (prio=1, hit=1).
module eaf_request_queue #(
  parameter int addr_length    = 32,
  parameter int fifo_depth     = 4,
  parameter int timeout_cycles = 64
) (
  input  logic               clk,
  input  logic               rst,
  eaf_request_queue_if.slave bus
);

  localparam int ptr_w = $clog2(fifo_depth);
  localparam int cnt_w = $clog2(fifo_depth + 1);
  localparam int tmr_w = $clog2(timeout_cycles + 1);

  typedef logic [addr_length-1:0] addr_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {OP_INSERT, OP_TEST} op_t;

  addr_t            evict_mem [fifo_depth];
  addr_t            miss_mem  [fifo_depth];
  logic [ptr_w-1:0] evict_wr_ptr, evict_rd_ptr, miss_wr_ptr, miss_rd_ptr;
  logic [cnt_w-1:0] evict_count, miss_count;
  logic             evict_full, evict_empty, miss_full, miss_empty;
  logic             push_evict, push_miss, pop_evict, pop_miss;

  state_t           state_q, state_d;
  op_t              op_q;
  addr_t            addr_q, head_addr;
  logic [tmr_w-1:0] timer_q;
  logic             prio_q, hit_q, timeout_q;
  logic             sel_miss, sel_evict, fwd_hit;
  logic             load_op, load_fwd, capture, timed_out;

  assign evict_full  = (evict_count == cnt_w'(fifo_depth));
  assign evict_empty = (evict_count == '0);
  assign miss_full   = (miss_count == cnt_w'(fifo_depth));
  assign miss_empty  = (miss_count == '0);
  assign push_evict  = bus.evict_valid_i && !evict_full;
  assign push_miss   = bus.miss_valid_i && !miss_full;

  // NOTE: FIFO storage is intentionally not reset; the pointers and counts alone define emptiness.
  always_ff @(posedge clk) begin
    if (push_evict) evict_mem[evict_wr_ptr] <= bus.evict_addr_i;
    if (push_miss)  miss_mem[miss_wr_ptr]   <= bus.miss_addr_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evict_wr_ptr <= '0;
      evict_rd_ptr <= '0;
      evict_count  <= '0;
      miss_wr_ptr  <= '0;
      miss_rd_ptr  <= '0;
      miss_count   <= '0;
    end else begin
      if (push_evict) evict_wr_ptr <= evict_wr_ptr + 1'b1;
      if (pop_evict)  evict_rd_ptr <= evict_rd_ptr + 1'b1;
      if (push_miss)  miss_wr_ptr  <= miss_wr_ptr + 1'b1;
      if (pop_miss)   miss_rd_ptr  <= miss_rd_ptr + 1'b1;
      evict_count <= evict_count + cnt_w'(push_evict) - cnt_w'(pop_evict);
      miss_count  <= miss_count + cnt_w'(push_miss) - cnt_w'(pop_miss);
    end
  end

  // Misses normally win; a full evict FIFO takes priority so evictions cannot stall forever.
  assign sel_miss  = !miss_empty && !evict_full;
  assign sel_evict = !evict_empty && !sel_miss;
  assign head_addr = sel_miss ? miss_mem[miss_rd_ptr] : evict_mem[evict_rd_ptr];

`ifdef EAF_REQ_FWD_EN
  // A miss on a line still waiting to be inserted is known to be in the EAF already.
  always_comb begin
    fwd_hit = 1'b0;
    for (int i = 0; i < fifo_depth; i++) begin
      if ((cnt_w'(i) < evict_count) &&
          (evict_mem[evict_rd_ptr + ptr_w'(i)] == miss_mem[miss_rd_ptr]))
        fwd_hit = 1'b1;
    end
  end
`else
  assign fwd_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every output of this block is defaulted first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    pop_evict = 1'b0;
    pop_miss  = 1'b0;
    load_op   = 1'b0;
    load_fwd  = 1'b0;
    capture   = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_miss) begin
          pop_miss = 1'b1;
          if (fwd_hit) begin
            load_fwd = 1'b1;
            state_d  = RESP;
          end else begin
            load_op = 1'b1;
            state_d = ISSUE;
          end
        end else if (sel_evict) begin
          pop_evict = 1'b1;
          load_op   = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.eaf_resp_i) begin
          capture = (op_q == OP_TEST);
          state_d = (op_q == OP_TEST) ? RESP : IDLE;
        end else if (timer_q == tmr_w'(timeout_cycles - 1)) begin
          timed_out = 1'b1;
          state_d   = (op_q == OP_TEST) ? RESP : IDLE;
        end
      end
      RESP: if (bus.prio_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q      <= OP_INSERT;
      addr_q    <= '0;
      timer_q   <= '0;
      prio_q    <= 1'b0;
      hit_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timed_out;
      if (load_op || load_fwd) begin
        addr_q <= head_addr;
        op_q   <= sel_miss ? OP_TEST : OP_INSERT;
      end
      if (state_q == ISSUE)     timer_q <= '0;
      else if (state_q == WAIT) timer_q <= timer_q + 1'b1;
      if (capture) begin
        prio_q <= bus.eaf_priority_i;
        hit_q  <= bus.eaf_exists_i;
      end else if (timed_out && op_q == OP_TEST) begin
        prio_q <= 1'b0;
        hit_q  <= 1'b0;
      end else if (load_fwd) begin
        prio_q <= 1'b1;
        hit_q  <= 1'b1;
      end
    end
  end

  assign bus.evict_ready_o = !evict_full;
  assign bus.miss_ready_o  = !miss_full;
  assign bus.eaf_addr_o    = addr_q;
  assign bus.eaf_insert_o  = (state_q == ISSUE) && (op_q == OP_INSERT);
  assign bus.eaf_test_o    = (state_q == ISSUE) && (op_q == OP_TEST);
  assign bus.prio_valid_o  = (state_q == RESP);
  assign bus.prio_o        = prio_q;
  assign bus.hit_o         = hit_q;
  assign bus.timeout_o     = timeout_q;

endmodule
